// File: rtl/axi4lite_reg_slave.sv
// ============================================================================
// Module   : axi4lite_reg_slave
// Brief    : AXI4-Lite slave with four 32-bit R/W control registers, exported
//            contents and per-register write pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        reg_wr_pulse
);

    localparam int         c_STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    logic                               r_rdy_en_q,   w_rdy_en_d;
    logic                               r_aw_held_q,  w_aw_held_d;
    logic [1:0]                         r_aw_idx_q,   w_aw_idx_d;
    logic                               r_w_held_q,   w_w_held_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]      r_wdata_q,    w_wdata_d;
    logic [c_STRB_W-1:0]                r_wstrb_q,    w_wstrb_d;
    logic                               r_bvalid_q,   w_bvalid_d;
    logic                               r_rvalid_q,   w_rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]      r_rdata_q,    w_rdata_d;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] r_regs_q,     w_regs_d;
    logic [3:0]                         r_wr_pulse_q, w_wr_pulse_d;

    logic                               w_aw_hs, w_w_hs, w_ar_hs;
    logic                               w_have_aw, w_have_w, w_commit;
    logic [1:0]                         w_wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      w_wr_data;
    logic [c_STRB_W-1:0]                w_wr_strb;
    logic                               w_unused;

    // Protection bits, byte offset and any address bits above [3:2] are don't-cares.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = r_rdy_en_q && !r_aw_held_q && !r_bvalid_q;
    assign S_AXI_WREADY  = r_rdy_en_q && !r_w_held_q  && !r_bvalid_q;
    assign S_AXI_ARREADY = r_rdy_en_q && !r_rvalid_q;
    assign S_AXI_BVALID  = r_bvalid_q;
    assign S_AXI_BRESP   = c_RESP_OKAY;
    assign S_AXI_RVALID  = r_rvalid_q;
    assign S_AXI_RDATA   = r_rdata_q;
    assign S_AXI_RRESP   = c_RESP_OKAY;
    assign reg_out       = r_regs_q;
    assign reg_wr_pulse  = r_wr_pulse_q;

    assign w_aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs    = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_have_aw = r_aw_held_q || w_aw_hs;
    assign w_have_w  = r_w_held_q  || w_w_hs;
    assign w_commit  = w_have_aw && w_have_w;

    // A handshake in the committing cycle bypasses its holding register.
    assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[3:2] : r_aw_idx_q;
    assign w_wr_data = w_w_hs  ? S_AXI_WDATA       : r_wdata_q;
    assign w_wr_strb = w_w_hs  ? S_AXI_WSTRB       : r_wstrb_q;

    always_comb begin
        w_rdy_en_d   = 1'b1;
        w_aw_held_d  = w_have_aw && !w_commit;
        w_aw_idx_d   = w_aw_hs ? S_AXI_AWADDR[3:2] : r_aw_idx_q;
        w_w_held_d   = w_have_w && !w_commit;
        w_wdata_d    = w_w_hs ? S_AXI_WDATA : r_wdata_q;
        w_wstrb_d    = w_w_hs ? S_AXI_WSTRB : r_wstrb_q;
        w_bvalid_d   = w_commit || (r_bvalid_q && !S_AXI_BREADY);
        w_rvalid_d   = w_ar_hs  || (r_rvalid_q && !S_AXI_RREADY);
        // Reads sample the pre-write register, so a colliding read sees old data.
        w_rdata_d    = w_ar_hs ? r_regs_q[S_AXI_ARADDR[3:2]] : r_rdata_q;
        w_regs_d     = r_regs_q;
        w_wr_pulse_d = 4'b0000;
        if (w_commit) begin
            w_wr_pulse_d[w_wr_idx] = 1'b1;
            for (int b = 0; b < c_STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    w_regs_d[w_wr_idx][8*b +: 8] = w_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdy_en_q   <= 1'b0;
            r_aw_held_q  <= 1'b0;
            r_aw_idx_q   <= 2'b00;
            r_w_held_q   <= 1'b0;
            r_wdata_q    <= '0;
            r_wstrb_q    <= '0;
            r_bvalid_q   <= 1'b0;
            r_rvalid_q   <= 1'b0;
            r_rdata_q    <= '0;
            r_regs_q     <= '0;
            r_wr_pulse_q <= 4'b0000;
        end else begin
            r_rdy_en_q   <= w_rdy_en_d;
            r_aw_held_q  <= w_aw_held_d;
            r_aw_idx_q   <= w_aw_idx_d;
            r_w_held_q   <= w_w_held_d;
            r_wdata_q    <= w_wdata_d;
            r_wstrb_q    <= w_wstrb_d;
            r_bvalid_q   <= w_bvalid_d;
            r_rvalid_q   <= w_rvalid_d;
            r_rdata_q    <= w_rdata_d;
            r_regs_q     <= w_regs_d;
            r_wr_pulse_q <= w_wr_pulse_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/axi4lite_reg_slave.md
Name: axi4lite_reg_slave

Overview:
- AXI4-Lite slave register file. It is the responder that the bench's VIP master drives with AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST.
- Provides four 32-bit read/write control registers, word-addressed at 0x0, 0x4, 0x8 and 0xC.
- Register contents and per-register write pulses are exported to the window-data-convert datapath.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; register index = addr[3:2].

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00 (OKAY).
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- reg_out  out  128  {reg3,reg2,reg1,reg0}; registered values.
- reg_wr_pulse  out  4  one-cycle pulse; bit k is high in the cycle after reg k is updated.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - reg0..reg3 = 0; reg_wr_pulse = 0.
  - BVALID = 0, RVALID = 0, RDATA = 0.
  - AW/W capture flags cleared.
  - AWREADY, WREADY and ARREADY become 1 the first cycle after reset releases.
  - Reset mid-transaction discards any half-captured AW/W and any pending B/R response.
- Write channel: AW and W are independent, one write outstanding at a time.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - An AW handshake latches the address and sets aw_held. A W handshake latches data and strobe and sets w_held. Handshakes may complete in the same cycle or in either order.
  - At the edge where the pair becomes complete (both held, or the completing handshake occurs):
    - the target register is updated byte-wise per WSTRB;
    - BVALID <= 1; aw_held and w_held are cleared;
    - reg_wr_pulse[idx] <= 1 for exactly one cycle.
  - The updated register is visible on reg_out the cycle after that edge.
  - BVALID holds until BREADY. AWREADY/WREADY stay low while BVALID = 1, so back-to-back writes take at least 2 cycles each.
  - WSTRB = 0 completes a normal OKAY response with no data change; the pulse still fires.
- Read channel:
  - ARREADY = !RVALID.
  - On an AR handshake at edge N: RDATA <= reg[ARADDR[3:2]] and RVALID <= 1.
  - RDATA and RVALID hold until RREADY; ARREADY goes high the cycle after the R handshake.
- Simultaneous read and write:
  - Channels run concurrently.
  - If a read samples the same register on the edge a write commits, the read returns the pre-write value.
- Address handling:
  - addr[1:0] is ignored; unaligned addresses map to the containing word.
  - Bits above [3:2] do not exist at the default width. For wider C_S_AXI_ADDR_WIDTH, the upper bits are ignored, giving aliasing with no error response.
- No SLVERR/DECERR is ever generated.

Test Plan:
- Sequential writes: 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB = 0xF, then read all four back -> RDATA 0x1, 0x2, 0x3, 0x4, every BRESP and RRESP = 0, reg_out = 0x00000004_00000003_00000002_00000001.
- Byte strobe: reg1 = 0x00000002, then write 0xAABBCCDD to 0x4 with WSTRB = 0b0010 -> reg1 reads 0x0000CC02; reg_wr_pulse = 0b0010 for exactly one cycle.
- Channel ordering:
  - W (0x55, addr 0x8) presented 3 cycles before AW -> WREADY drops after capture, BVALID rises only on the AW handshake edge, reg2 = 0x55.
  - Repeat with AW first -> same result.
- Backpressure:
  - BREADY held low 5 cycles after a write -> BVALID stays 1, AWREADY = WREADY = 0, and a second presented write is not accepted until the B handshake.
  - RREADY held low -> RDATA stable, ARREADY = 0.
- Collision: reg3 = 0x11; AR to 0xC and AW/W of 0x22 to 0xC in the same cycle -> RDATA = 0x11, subsequent read = 0x22.
- Reset mid-operation: AW accepted but no W, plus an R pending, then ARESET pulsed -> BVALID = 0, RVALID = 0, all regs 0, ready signals 1 after release; a later W alone does not produce BVALID.
